// File: rtl/cx4_rom_fetch.sv
// cx4_rom_fetch: multi-byte ROM operand fetch for the CX4 core.
// One request (start address + 1..3 bytes) becomes a series of single-byte
// reads on the master FSM's ROM port. The bytes are packed little-endian into
// DATA, and the last good result is kept in a one-entry cache.
//
// Bus handshake: BUS_RDY is a level owned by the master. High means the master
// is idle and BUS_DI holds the byte of the last completed read. A read is
// requested with a one-cycle BUS_RRQ pulse, which is only issued while BUS_RDY
// is high. The master drops BUS_RDY one cycle later and raises it again once
// BUS_DI is valid. BUS_ADDR is held from the issue cycle until that byte is
// captured.
module cx4_rom_fetch #(
  parameter int TIMEOUT  = 255,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        REQ,
  input  logic [23:0] REQ_ADDR,
  input  logic [1:0]  REQ_LEN,
  input  logic        INVALIDATE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [23:0] DATA,
  output logic        HIT,
  output logic [23:0] BUS_ADDR,
  output logic        BUS_RRQ,
  input  logic        BUS_RDY,
  input  logic [7:0]  BUS_DI,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  state_t      state;
  logic [23:0] req_addr;     // start address of the fetch in progress (cache tag)
  logic [1:0]  len;          // effective byte count, 1..3
  logic [1:0]  idx;          // lane currently being fetched
  logic [7:0]  tmo_cnt;      // cycles spent waiting on the current byte
  logic        cache_valid;
  logic [23:0] tag_addr;
  logic [1:0]  tag_len;
  logic [23:0] cache_data;

  logic [1:0]  eff_len;
  logic        cache_hit;

  // Request decode: length 0 means 3 bytes; hit requires address and length match.
  always_comb begin
    eff_len   = (REQ_LEN == 2'd0) ? 2'd3 : REQ_LEN;
    cache_hit = CACHE_EN && cache_valid && (tag_addr == REQ_ADDR) &&
                (tag_len == eff_len) && !INVALIDATE;
  end

  assign BUSY  = (state != S_IDLE);
  assign STATE = state;

  // Fetch sequencer, bus outputs, result registers and the result cache.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      HIT         <= 1'b0;
      DATA        <= '0;
      BUS_ADDR    <= '0;
      BUS_RRQ     <= 1'b0;
      req_addr    <= '0;
      len         <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      cache_valid <= 1'b0;
      tag_addr    <= '0;
      tag_len     <= '0;
      cache_data  <= '0;
    end else begin
      BUS_RRQ <= 1'b0;
      DONE    <= 1'b0;
      if (INVALIDATE) cache_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ) begin
            req_addr <= REQ_ADDR;
            len      <= eff_len;
            idx      <= 2'd0;
            ERR      <= 1'b0;
            if (cache_hit) begin
              DATA  <= cache_data;
              HIT   <= 1'b1;
              DONE  <= 1'b1;
              state <= S_FIN;
            end else begin
              DATA     <= '0;
              HIT      <= 1'b0;
              BUS_ADDR <= REQ_ADDR;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // A low BUS_RDY here is a read left over from before a reset; wait it out.
          if (BUS_RDY) begin
            BUS_RRQ <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (tmo_cnt == TMO_LIMIT) begin
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= S_FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (!BUS_RDY) state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (BUS_RDY) begin
            DATA[{idx, 3'b000} +: 8] <= BUS_DI;
            if (idx == len - 2'd1) begin
              DONE  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx      <= idx + 2'd1;
              BUS_ADDR <= BUS_ADDR + 24'd1;
              state    <= S_ISSUE;
            end
          end else if (tmo_cnt == TMO_LIMIT) begin
            ERR   <= 1'b1;
            DONE  <= 1'b1;
            state <= S_FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          // Only a complete bus result is cached; an INVALIDATE this cycle wins.
          if (CACHE_EN && !ERR && !HIT && !INVALIDATE) begin
            cache_valid <= 1'b1;
            tag_addr    <= req_addr;
            tag_len     <= len;
            cache_data  <= DATA;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cx4_rom_fetch.sv
// tb_cx4_rom_fetch: directed and randomized checks of cx4_rom_fetch against a
// byte-level reference model (ROM contents function + one-entry cache model).
module tb_cx4_rom_fetch;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        REQ = 1'b0;
  logic [23:0] REQ_ADDR = '0;
  logic [1:0]  REQ_LEN = '0;
  logic        INVALIDATE = 1'b0;
  logic        BUSY, DONE, ERR, HIT, BUS_RRQ;
  logic [23:0] DATA, BUS_ADDR;
  logic [2:0]  STATE;
  logic        BUS_RDY = 1'b1;
  logic [7:0]  BUS_DI = '0;

  int checks = 0;
  int failures = 0;

  cx4_rom_fetch #(.TIMEOUT(255), .CACHE_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .INVALIDATE(INVALIDATE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DATA(DATA),
    .HIT(HIT), .BUS_ADDR(BUS_ADDR), .BUS_RRQ(BUS_RRQ), .BUS_RDY(BUS_RDY),
    .BUS_DI(BUS_DI), .STATE(STATE)
  );

  // ---------------- clock / cycle count ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM contents and bus master model ----------------
  logic [7:0] mem_seed = 8'h00;
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ mem_seed;
  endfunction

  logic [23:0] rrq_log[$];     // every BUS_ADDR seen with BUS_RRQ
  logic [23:0] exp_q[$];       // addresses the model expects to be read
  int          bus_lat = 8;    // cycles BUS_RDY stays low per read
  logic        bus_hang = 1'b0;
  logic        bus_pend = 1'b0;
  logic        bus_stale = 1'b0;
  int          bus_cnt = 0;
  logic [23:0] bus_addr_l = '0;
  int          rrq_cyc = 0;
  int          rrq_viol = 0;   // RRQ while a read was still pending
  int          addr_glitch = 0;// BUS_ADDR moved while its read was pending

  always @(negedge CLK) begin
    if (!nRST && bus_pend) bus_stale = 1'b1;
    if (bus_pend) begin
      if (!bus_stale && BUS_ADDR !== bus_addr_l) addr_glitch = addr_glitch + 1;
      if (!bus_hang) begin
        if (bus_cnt <= 0) begin
          BUS_RDY   = 1'b1;
          BUS_DI    = mem_byte(bus_addr_l);
          bus_pend  = 1'b0;
          bus_stale = 1'b0;
        end else begin
          bus_cnt = bus_cnt - 1;
        end
      end
    end
    if (BUS_RRQ === 1'b1) begin
      if (bus_pend) rrq_viol = rrq_viol + 1;
      rrq_log.push_back(BUS_ADDR);
      rrq_cyc    = cyc;
      bus_addr_l = BUS_ADDR;
      bus_pend   = 1'b1;
      bus_cnt    = bus_lat - 1;
      BUS_RDY    = 1'b0;
      BUS_DI     = 8'($urandom);
    end
  end

  // ---------------- reference model ----------------
  logic        m_valid = 1'b0;
  logic [23:0] m_addr = '0;
  logic [1:0]  m_len = '0;
  logic [23:0] m_data = '0;

  // Expected outcome of one request; fills exp_q with the byte addresses to be read.
  task automatic model_fetch(input logic [23:0] a, input logic [1:0] l, input logic inval,
                             input logic hang, output logic [23:0] d, output logic h,
                             output logic e);
    int n;
    logic [23:0] ai;
    n = (l == 2'd0) ? 3 : int'(l);
    exp_q.delete();
    h = m_valid && (m_addr == a) && (int'(m_len) == n) && !inval;
    if (inval) m_valid = 1'b0;
    d = '0;
    e = 1'b0;
    if (h) begin
      d = m_data;
    end else if (hang) begin
      e = 1'b1;
      exp_q.push_back(a);
    end else begin
      for (int i = 0; i < n; i++) begin
        ai = a + 24'(i);
        exp_q.push_back(ai);
        d[8*i +: 8] = mem_byte(ai);
      end
      m_valid = 1'b1;
      m_addr  = a;
      m_len   = 2'(n);
      m_data  = d;
    end
  endtask

  function automatic bit addr_list_ok();
    if (rrq_log.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (rrq_log[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  int done_cyc = 0;

  // Issue one request and observe its completion. hold keeps REQ high through
  // FIN; inv_fin pulses INVALIDATE in the FIN cycle.
  task automatic run_fetch(input logic [23:0] a, input logic [1:0] l, input logic inval,
                           input logic hold, input logic inv_fin,
                           output logic [23:0] d, output logic h, output logic e,
                           output int lat, output int ndone, output logic [23:0] d_after,
                           output logic timed_out);
    rrq_log.delete();
    lat = 0; ndone = 0; timed_out = 1'b1; d = '0; h = 1'b0; e = 1'b0;
    @(negedge CLK);
    REQ = 1'b1; REQ_ADDR = a; REQ_LEN = l; INVALIDATE = inval;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      lat = lat + 1;
      if (!hold) REQ = 1'b0;
      INVALIDATE = 1'b0;
      if (DONE) begin
        ndone = ndone + 1;
        d = DATA; h = HIT; e = ERR;
        done_cyc  = cyc;
        timed_out = 1'b0;
        if (inv_fin) INVALIDATE = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      REQ = 1'b0; INVALIDATE = 1'b0;
      if (DONE) ndone = ndone + 1;
    end
    d_after = DATA;
  endtask

  logic [23:0] d, ed, d_after;
  logic h, eh, e, ee, tmo;
  int lat, ndone;

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if ({BUSY, DONE, ERR, HIT, BUS_RRQ} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got %b exp 00000", {BUSY, DONE, ERR, HIT, BUS_RRQ}); end
    checks++; if (DATA !== 24'h0 || BUS_ADDR !== 24'h0) begin failures++;
      $display("FAIL reset_data got data=%h addr=%h exp 0/0", DATA, BUS_ADDR); end
    checks++; if (STATE !== 3'd0) begin failures++;
      $display("FAIL reset_state got %0d exp 0", STATE); end
    #2 nRST = 1'b1;
  endtask

  task automatic test_miss_wrap();
    bus_lat = 8;
    model_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL miss3_done_timeout got no DONE exp DONE"); end
    checks++; if (d !== ed) begin failures++; $display("FAIL miss3_data got %h exp %h", d, ed); end
    checks++; if (h !== 1'b0 || e !== 1'b0) begin failures++;
      $display("FAIL miss3_hit_err got hit=%b err=%b exp 0/0", h, e); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL miss3_done_count got %0d exp 1", ndone); end
    checks++; if (!addr_list_ok()) begin failures++;
      $display("FAIL miss3_bus_addrs got n=%0d exp n=%0d (00fffe,00ffff,010000)", rrq_log.size(), exp_q.size()); end
    checks++; if (d_after !== ed || BUSY !== 1'b0) begin failures++;
      $display("FAIL miss3_hold got data=%h busy=%b exp %h/0", d_after, BUSY, ed); end
  endtask

  task automatic test_cache_hit();
    model_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (h !== eh || d !== ed) begin failures++;
      $display("FAIL hit_result got hit=%b data=%h exp hit=%b data=%h", h, d, eh, ed); end
    // REQ presented for one cycle; DONE must be up in the very next cycle.
    checks++; if (lat != 1) begin failures++; $display("FAIL hit_latency got %0d exp 1", lat); end
    checks++; if (rrq_log.size() != 0) begin failures++;
      $display("FAIL hit_no_rrq got %0d exp 0", rrq_log.size()); end
    @(negedge CLK); INVALIDATE = 1'b1;
    @(negedge CLK); INVALIDATE = 1'b0;
    m_valid = 1'b0;
    model_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (h !== 1'b0 || !addr_list_ok() || d !== ed) begin failures++;
      $display("FAIL inval_miss got hit=%b rrqs=%0d data=%h exp hit=0 rrqs=%0d data=%h",
               h, rrq_log.size(), d, exp_q.size(), ed); end
    // Hit with INVALIDATE in its FIN cycle: the entry must be gone afterwards.
    model_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, 1'b1, d, h, e, lat, ndone, d_after, tmo);
    m_valid = 1'b0;
    checks++; if (h !== 1'b1) begin failures++; $display("FAIL hit_before_fin_inval got %b exp 1", h); end
    model_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'h00FFFE, 2'd3, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (h !== 1'b0 || !addr_list_ok()) begin failures++;
      $display("FAIL fin_inval_miss got hit=%b rrqs=%0d exp hit=0 rrqs=%0d", h, rrq_log.size(), exp_q.size()); end
  endtask

  task automatic test_len_wrap();
    bus_lat = 3;
    model_fetch(24'hFFFFFF, 2'd1, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'hFFFFFF, 2'd1, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (d !== ed || !addr_list_ok()) begin failures++;
      $display("FAIL len1_top got data=%h rrqs=%0d exp data=%h rrqs=1", d, rrq_log.size(), ed); end
    model_fetch(24'hFFFFFF, 2'd2, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(24'hFFFFFF, 2'd2, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (h !== 1'b0) begin failures++; $display("FAIL len2_false_hit got %b exp 0", h); end
    checks++; if (!addr_list_ok()) begin failures++;
      $display("FAIL len2_wrap_addrs got n=%0d first=%h exp ffffff,000000", rrq_log.size(),
               (rrq_log.size() > 0) ? rrq_log[0] : 24'h0); end
    checks++; if (d !== ed || d[23:16] !== 8'h00) begin failures++;
      $display("FAIL len2_data got %h exp %h", d, ed); end
  endtask

  task automatic test_timeout();
    logic [23:0] a;
    logic [1:0]  l;
    a = 24'($urandom); l = 2'($urandom_range(1, 3));
    bus_lat = 3; bus_hang = 1'b1;
    model_fetch(a, l, 1'b0, 1'b1, ed, eh, ee);
    run_fetch(a, l, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (tmo !== 1'b0 || e !== 1'b1 || d !== 24'h0) begin failures++;
      $display("FAIL tmo_result got done=%b err=%b data=%h exp 1/1/000000", !tmo, e, d); end
    checks++; if (done_cyc - rrq_cyc != 256) begin failures++;
      $display("FAIL tmo_latency got %0d exp 256", done_cyc - rrq_cyc); end
    checks++; if (ndone != 1 || !addr_list_ok()) begin failures++;
      $display("FAIL tmo_pulse got dones=%0d rrqs=%0d exp 1/1", ndone, rrq_log.size()); end
    bus_hang = 1'b0;
    repeat (6) @(negedge CLK);
    model_fetch(a, l, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(a, l, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (h !== 1'b0 || e !== 1'b0 || d !== ed || !addr_list_ok()) begin failures++;
      $display("FAIL tmo_retry got hit=%b err=%b data=%h exp 0/0/%h", h, e, d, ed); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [23:0] b;
    bus_lat = 30;
    @(negedge CLK);
    REQ = 1'b1; REQ_ADDR = 24'h123456; REQ_LEN = 2'd3;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      REQ = 1'b0;
      if (STATE == 3'd3) break;
    end
    repeat (2) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    checks++; if ({BUSY, DONE, ERR, HIT, BUS_RRQ} !== 5'b0 || STATE !== 3'd0) begin failures++;
      $display("FAIL midreset_flags got %b state=%0d exp 00000 state=0", {BUSY, DONE, ERR, HIT, BUS_RRQ}, STATE); end
    checks++; if (DATA !== 24'h0 || BUS_ADDR !== 24'h0) begin failures++;
      $display("FAIL midreset_data got data=%h addr=%h exp 0/0", DATA, BUS_ADDR); end
    m_valid = 1'b0;
    @(negedge CLK);
    #2 nRST = 1'b1;
    bus_lat = 4;
    b = 24'($urandom);
    model_fetch(b, 2'd2, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(b, 2'd2, 1'b0, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (tmo !== 1'b0 || d !== ed || e !== 1'b0 || h !== 1'b0) begin failures++;
      $display("FAIL post_reset_fetch got data=%h err=%b hit=%b exp %h/0/0", d, e, h, ed); end
    checks++; if (rrq_viol != 0 || !addr_list_ok()) begin failures++;
      $display("FAIL post_reset_stall got early_rrqs=%0d rrqs=%0d exp 0/%0d", rrq_viol, rrq_log.size(), exp_q.size()); end
  endtask

  task automatic test_req_hold();
    logic [23:0] a;
    logic [1:0]  l;
    a = 24'($urandom); l = 2'($urandom_range(0, 3));
    bus_lat = 5;
    model_fetch(a, l, 1'b0, 1'b0, ed, eh, ee);
    run_fetch(a, l, 1'b0, 1'b1, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (ndone != 1 || !addr_list_ok()) begin failures++;
      $display("FAIL hold_one_fetch got dones=%0d rrqs=%0d exp 1/%0d", ndone, rrq_log.size(), exp_q.size()); end
    checks++; if (d !== ed || d_after !== ed) begin failures++;
      $display("FAIL hold_data got %h after=%h exp %h", d, d_after, ed); end
    model_fetch(a, l, 1'b1, 1'b0, ed, eh, ee);
    run_fetch(a, l, 1'b1, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
    checks++; if (h !== 1'b0 || !addr_list_ok() || d !== ed) begin failures++;
      $display("FAIL req_inval_miss got hit=%b rrqs=%0d data=%h exp 0/%0d/%h", h, rrq_log.size(), d, exp_q.size(), ed); end
  endtask

  task automatic test_random();
    logic [23:0] pool[4];
    logic [23:0] a;
    logic [1:0]  l;
    logic        inv;
    int          bad;
    pool[0] = 24'hFFFFFE; pool[1] = 24'($urandom);
    pool[2] = 24'($urandom); pool[3] = 24'h000000;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      a = pool[$urandom_range(0, 3)];
      l = 2'($urandom_range(0, 3));
      inv = ($urandom_range(0, 5) == 0);
      bus_lat = $urandom_range(1, 6);
      model_fetch(a, l, inv, 1'b0, ed, eh, ee);
      run_fetch(a, l, inv, 1'b0, 1'b0, d, h, e, lat, ndone, d_after, tmo);
      checks++;
      if (tmo !== 1'b0 || d !== ed || h !== eh || e !== 1'b0 || ndone != 1 ||
          !addr_list_ok() || d_after !== ed) begin
        failures++;
        $display("FAIL rand_%0d addr=%h len=%0d got data=%h hit=%b err=%b dones=%0d rrqs=%0d exp data=%h hit=%b rrqs=%0d",
                 i, a, l, d, h, e, ndone, rrq_log.size(), ed, eh, exp_q.size());
      end
    end
    checks++; if (addr_glitch != 0 || rrq_viol != 0) begin failures++;
      $display("FAIL bus_protocol got addr_moves=%0d early_rrqs=%0d exp 0/0", addr_glitch, rrq_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mem_seed = 8'($urandom);
    test_reset();
    test_miss_wrap();
    test_cache_hit();
    test_len_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_req_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
